// File: rtl/gray_pkg.sv
// Shared constants and helpers for the binary/Gray conversion pair.
package gray_pkg;

  localparam int unsigned GRAY_DEFAULT_WIDTH = 4;
  localparam int unsigned GRAY_MAX_WIDTH     = 32;

  // Narrower values are zero-extended, so the Gray MSB equals the binary MSB.
  function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] value);
    return value ^ (value >> 1);
  endfunction

  function automatic int unsigned popcount(input logic [GRAY_MAX_WIDTH-1:0] value);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < GRAY_MAX_WIDTH; i++) begin
      cnt += int'(value[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/bin_gray_enc.sv
// Combinational binary-to-Gray encoder, WIDTH bits wide.
module bin_gray_enc
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = GRAY_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);

  always_comb begin
    gray_o = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(bin_i)));
  end

endmodule

// File: rtl/bin_gray_counter.sv
// Registered up/down counter with a registered Gray-coded copy of the count.
// Define GRAY_STEP_CHECK_EN to build the sticky single-bit-step checker driving err_o.
module bin_gray_counter
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = GRAY_DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             up_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_bin_i,
  output logic [WIDTH-1:0] bin_o,
  output logic [WIDTH-1:0] gray_o,
  output logic             wrap_o,
  output logic             err_o
);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;

  // Priority: load, then count, then hold.
  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (load_i) begin
      bin_d = load_bin_i;
    end else if (en_i) begin
      if (up_i) begin
        bin_d  = bin_q + WIDTH'(1);
        wrap_d = &bin_q;
      end else begin
        bin_d  = bin_q - WIDTH'(1);
        wrap_d = ~|bin_q;
      end
    end
  end

  // Gray is encoded from the next binary value so both registers flip on the same edge.
  bin_gray_enc #(
    .WIDTH(WIDTH)
  ) u_enc (
    .bin_i (bin_d),
    .gray_o(gray_d)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bin_o  = bin_q;
  assign gray_o = gray_q;
  assign wrap_o = wrap_q;

`ifdef GRAY_STEP_CHECK_EN
  logic [WIDTH-1:0] prev_gray_q;
  logic             step_q;
  logic             err_q, err_d;
  int unsigned      diff_bits;

  // Only updates caused by a count step are held to the one-bit rule.
  always_comb begin
    diff_bits = popcount(GRAY_MAX_WIDTH'(gray_q ^ prev_gray_q));
    err_d     = err_q | (step_q && (diff_bits != 1));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_gray_q <= '0;
      step_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      prev_gray_q <= gray_q;
      step_q      <= en_i & ~load_i;
      err_q       <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_bin_gray_counter.sv
// Scoreboard bench for bin_gray_counter at WIDTH=4; honours GRAY_STEP_CHECK_EN.
module tb_bin_gray_counter;

  localparam int unsigned W = 4;

`ifdef GRAY_STEP_CHECK_EN
  localparam logic ErrOnFault = 1'b1;
`else
  localparam logic ErrOnFault = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, en, up, load;
  logic [W-1:0] load_bin, bin, gray;
  logic         wrap, err;

  always #5 clk = ~clk;

  bin_gray_counter #(
    .WIDTH(W)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .en_i      (en),
    .up_i      (up),
    .load_i    (load),
    .load_bin_i(load_bin),
    .bin_o     (bin),
    .gray_o    (gray),
    .wrap_o    (wrap),
    .err_o     (err)
  );

  typedef struct packed {
    logic [W-1:0] bin;
    logic [W-1:0] gray;
    logic         wrap;
    logic         err;
  } exp_t;

  exp_t         sb_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W-1:0] m_bin;
  logic         m_wrap;
  logic         m_err;

  logic [W-1:0] up_seq [16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101,
                                 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010,
                                 4'b1011, 4'b1001, 4'b1000, 4'b0000};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_gray(input logic [W-1:0] b);
    logic [W-1:0] g;
    g[W-1] = b[W-1];
    for (int i = 0; i < W - 1; i++) g[i] = b[i] ^ b[i+1];
    return g;
  endfunction

  // Drive one cycle of controls, predict, then compare after the edge.
  task automatic step(input logic e, input logic u, input logic l, input logic [W-1:0] lb);
    exp_t x;
    @(negedge clk);
    en = e; up = u; load = l; load_bin = lb;
    if (l) begin
      m_bin  = lb;
      m_wrap = 1'b0;
    end else if (e) begin
      if (u) begin
        m_wrap = (m_bin == 4'hf);
        m_bin  = m_bin + 4'd1;
      end else begin
        m_wrap = (m_bin == 4'h0);
        m_bin  = m_bin - 4'd1;
      end
    end else begin
      m_wrap = 1'b0;
    end
    x = '{bin: m_bin, gray: ref_gray(m_bin), wrap: m_wrap, err: m_err};
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_val("sb_underflow", 32'(sb_q.size()), 32'd1);
    end else begin
      x = sb_q.pop_front();
      check_val("sb_bin", 32'(bin), 32'(x.bin));
      check_val("sb_gray", 32'(gray), 32'(x.gray));
      check_val("sb_wrap", 32'(wrap), 32'(x.wrap));
      check_val("sb_err", 32'(err), 32'(x.err));
    end
  endtask

  task automatic drive(input logic e, input logic u, input logic l, input logic [W-1:0] lb);
    @(negedge clk);
    en = e; up = u; load = l; load_bin = lb;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; load_bin = '0;
    m_bin = '0; m_wrap = 1'b0; m_err = 1'b0;
    #12;
    check_val("rst_bin", 32'(bin), 32'd0);
    check_val("rst_gray", 32'(gray), 32'd0);
    check_val("rst_wrap", 32'(wrap), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Full up cycle through all 16 codes.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, 1'b0, '0);
      check_val("up_seq_gray", 32'(gray), 32'(up_seq[i]));
      check_val("up_seq_wrap", 32'(wrap), (i == 15) ? 32'd1 : 32'd0);
    end

    // Down from 0 wraps to all-ones.
    step(1'b1, 1'b0, 1'b0, '0);
    check_val("down_wrap_bin", 32'(bin), 32'hf);
    check_val("down_wrap_gray", 32'(gray), 32'h8);
    step(1'b1, 1'b0, 1'b0, '0);
    check_val("down2_gray", 32'(gray), 32'h9);

    // Load beats enable.
    step(1'b1, 1'b1, 1'b1, 4'b1011);
    check_val("load_gray", 32'(gray), 32'b1110);
    step(1'b1, 1'b1, 1'b0, '0);
    check_val("post_load_gray", 32'(gray), 32'b1010);

    // Hold, then direction reversal every cycle.
    step(1'b0, 1'b0, 1'b1, 4'b0110);
    repeat (5) step(1'b0, 1'b1, 1'b0, '0);
    check_val("hold_gray", 32'(gray), 32'b0101);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, (i % 2) == 1, 1'b0, '0);
      check_val("toggle_gray", 32'(gray), (i % 2) == 1 ? 32'b0101 : 32'b0111);
    end

    // Loads of boundary values never pulse wrap; counting off them does.
    step(1'b1, 1'b1, 1'b1, 4'hf);
    step(1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, 4'h0);
    step(1'b1, 1'b0, 1'b0, '0);

    // Asynchronous reset in mid-cycle while enabled.
    step(1'b0, 1'b0, 1'b1, 4'b0101);
    #2;
    en = 1'b1; up = 1'b1; load = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check_val("async_rst_bin", 32'(bin), 32'd0);
    check_val("async_rst_gray", 32'(gray), 32'd0);
    check_val("async_rst_wrap", 32'(wrap), 32'd0);
    check_val("async_rst_err", 32'(err), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_held_bin", 32'(bin), 32'd0);
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    m_bin = '0; m_wrap = 1'b0;
    step(1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, '0);

    // Corrupt gray right after a count step.
    force dut.gray_q = 4'b0110;
    drive(1'b0, 1'b0, 1'b0, '0);
    release dut.gray_q;
    check_val("fault_err", 32'(err), 32'(ErrOnFault));
    drive(1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, 1'b0, '0);
    check_val("fault_err_sticky", 32'(err), 32'(ErrOnFault));
    rst = 1'b1;
    #1;
    check_val("fault_err_cleared", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    check_val("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
